load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 235 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op from the pipeline, drives a single-beat
// data-memory handshake, and returns sign/zero-extended load data.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_mem_write,
    input  logic        ctrl_mem2reg,
    input  logic [2:0]  ctrl_load_size,
    input  logic [2:0]  ctrl_store_size,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        lsu_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        lsu_fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [2:0]  size_r;
    logic [1:0]  offset_r;
    logic        is_load_r;

    logic        op_present_s;
    logic        is_store_s;
    logic [2:0]  size_s;
    logic        op_fault_s;
    logic        accept_s;

    // Stores may only use byte/half/word; loads additionally allow the unsigned forms.
    function automatic logic size_legal(input logic is_store, input logic [2:0] size);
        logic ok;
        case (size)
            3'b000, 3'b001, 3'b010: ok = 1'b1;
            3'b100, 3'b101:         ok = ~is_store;
            default:                ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] offset);
        logic bad;
        case (size[1:0])
            2'b01:   bad = offset[0];
            2'b10:   bad = (offset != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enables(input logic is_store, input logic [2:0] size,
                                                input logic [1:0] offset);
        logic [3:0] be;
        if (is_store) begin
            case (size)
                3'b000:  be = 4'b0001 << offset;
                3'b001:  be = 4'b0011 << {offset[1], 1'b0};
                default: be = 4'b1111;
            endcase
        end else begin
            be = 4'b1111;
        end
        return be;
    endfunction

    function automatic logic [31:0] write_data(input logic is_store, input logic [2:0] size,
                                               input logic [31:0] data);
        logic [31:0] wd;
        if (is_store) begin
            case (size)
                3'b000:  wd = {4{data[7:0]}};
                3'b001:  wd = {2{data[15:0]}};
                default: wd = data;
            endcase
        end else begin
            wd = 32'd0;
        end
        return wd;
    endfunction

    function automatic logic [31:0] extract_load(input logic [2:0] size, input logic [1:0] offset,
                                                 input logic [31:0] rdata);
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        logic [31:0] res;
        case (offset)
            2'b00:   lane_b = rdata[7:0];
            2'b01:   lane_b = rdata[15:8];
            2'b10:   lane_b = rdata[23:16];
            2'b11:   lane_b = rdata[31:24];
            default: lane_b = 8'd0;
        endcase
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            3'b000:  res = {{24{lane_b[7]}}, lane_b};
            3'b100:  res = {24'd0, lane_b};
            3'b001:  res = {{16{lane_h[15]}}, lane_h};
            3'b101:  res = {16'd0, lane_h};
            3'b010:  res = rdata;
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // Decode of the op currently offered by the pipeline (a store wins if both flags are set).
    always_comb begin
        op_present_s = ctrl_mem_write | ctrl_mem2reg;
        is_store_s   = ctrl_mem_write;
        size_s       = ctrl_mem_write ? ctrl_store_size : ctrl_load_size;
        op_fault_s   = op_present_s &
                       (~size_legal(is_store_s, size_s) | misaligned(size_s, addr[1:0]));
        accept_s     = (state_r == IDLE) & op_present_s & ~op_fault_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = BUSY;
                end
            end
            RESP:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Combinational handshake back to the pipeline.
    always_comb begin
        lsu_stall = 1'b0;
        lsu_fault = 1'b0;
        case (state_r)
            IDLE: begin
                lsu_stall = accept_s;
                lsu_fault = op_fault_s;
            end
            BUSY: begin
                lsu_stall = 1'b1;
                lsu_fault = 1'b0;
            end
            default: begin
                lsu_stall = 1'b0;
                lsu_fault = 1'b0;
            end
        endcase
    end

    // Registered memory-side outputs and load result; everything after accept uses latched op info.
    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'd0;
            dmem_be    <= 4'd0;
            dmem_wdata <= 32'd0;
            load_data  <= 32'd0;
            load_valid <= 1'b0;
            size_r     <= 3'd0;
            offset_r   <= 2'd0;
            is_load_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    load_valid <= 1'b0;
                    if (accept_s) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store_s;
                        dmem_addr  <= {addr[31:2], 2'b00};
                        dmem_be    <= byte_enables(is_store_s, size_s, addr[1:0]);
                        dmem_wdata <= write_data(is_store_s, size_s, store_data);
                        size_r     <= size_s;
                        offset_r   <= addr[1:0];
                        is_load_r  <= ~is_store_s;
                    end else begin
                        dmem_req   <= 1'b0;
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        if (is_load_r) begin
                            load_data  <= extract_load(size_r, offset_r, dmem_rdata);
                            load_valid <= 1'b1;
                        end else begin
                            load_valid <= 1'b0;
                        end
                    end else begin
                        dmem_req <= 1'b1;
                    end
                end
                RESP: begin
                    dmem_req   <= 1'b0;
                    load_valid <= 1'b0;
                end
                default: begin
                    dmem_req   <= 1'b0;
                    load_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: expected requests and load results are queued
// when an op is driven and popped when the DUT presents them.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        ctrl_mem_write;
    logic        ctrl_mem2reg;
    logic [2:0]  ctrl_load_size;
    logic [2:0]  ctrl_store_size;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        lsu_stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        lsu_fault;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    req_t        exp_req_q[$];
    logic [31:0] exp_load_q[$];
    int          errors;
    int          checks;

    load_store_unit dut (
        .clk             (clk),
        .rst             (rst),
        .ctrl_mem_write  (ctrl_mem_write),
        .ctrl_mem2reg    (ctrl_mem2reg),
        .ctrl_load_size  (ctrl_load_size),
        .ctrl_store_size (ctrl_store_size),
        .addr            (addr),
        .store_data      (store_data),
        .lsu_stall       (lsu_stall),
        .load_data       (load_data),
        .load_valid      (load_valid),
        .lsu_fault       (lsu_fault),
        .dmem_req        (dmem_req),
        .dmem_we         (dmem_we),
        .dmem_addr       (dmem_addr),
        .dmem_be         (dmem_be),
        .dmem_wdata      (dmem_wdata),
        .dmem_ack        (dmem_ack),
        .dmem_rdata      (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ctrl_mem_write  = 1'b0;
        ctrl_mem2reg    = 1'b0;
        ctrl_load_size  = 3'b000;
        ctrl_store_size = 3'b000;
        addr            = 32'd0;
        store_data      = 32'd0;
    endtask

    // Full legal access; ack is raised after ack_wait BUSY cycles without ack.
    task automatic do_op(input logic wr, input logic rd, input logic [2:0] lsz, input logic [2:0] ssz,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                         input int ack_wait, input logic [3:0] ebe, input logic [31:0] eaddr,
                         input logic [31:0] ewdata, input logic [31:0] eload);
        req_t        e;
        logic [31:0] el;
        logic        is_load;
        is_load = ~wr;
        el = 32'd0;
        e.we = wr; e.addr = eaddr; e.be = ebe; e.wdata = ewdata;
        exp_req_q.push_back(e);
        if (is_load) exp_load_q.push_back(eload);
        ctrl_mem_write = wr; ctrl_mem2reg = rd;
        ctrl_load_size = lsz; ctrl_store_size = ssz;
        addr = a; store_data = sd;
        #1;
        check("accept_stall", {31'd0, lsu_stall}, 32'd1);
        check("accept_fault", {31'd0, lsu_fault}, 32'd0);
        step();
        check("sb_req_avail", exp_req_q.size(), 32'd1);
        e = exp_req_q.pop_front();
        for (int i = 0; i <= ack_wait; i++) begin
            check("busy_req",   {31'd0, dmem_req},  32'd1);
            check("busy_we",    {31'd0, dmem_we},   {31'd0, e.we});
            check("busy_addr",  dmem_addr,          e.addr);
            check("busy_be",    {28'd0, dmem_be},   {28'd0, e.be});
            check("busy_wdata", dmem_wdata,         e.wdata);
            check("busy_stall", {31'd0, lsu_stall}, 32'd1);
            if (i == ack_wait) begin
                dmem_ack = 1'b1;
                dmem_rdata = rdata;
            end
            step();
        end
        dmem_ack = 1'b0;
        dmem_rdata = 32'hDEAD_BEEF;
        idle_inputs();
        #1;
        check("resp_req",   {31'd0, dmem_req},   32'd0);
        check("resp_stall", {31'd0, lsu_stall},  32'd0);
        check("resp_valid", {31'd0, load_valid}, {31'd0, is_load});
        if (is_load) begin
            check("sb_load_avail", exp_load_q.size(), 32'd1);
            el = exp_load_q.pop_front();
            check("resp_load_data", load_data, el);
        end
        step();
        check("idle_valid", {31'd0, load_valid}, 32'd0);
        if (is_load) check("idle_load_hold", load_data, el);
    endtask

    // Illegal or misaligned op: fault reported, nothing issued.
    task automatic fault_op(input logic wr, input logic rd, input logic [2:0] lsz,
                            input logic [2:0] ssz, input logic [31:0] a);
        ctrl_mem_write = wr; ctrl_mem2reg = rd;
        ctrl_load_size = lsz; ctrl_store_size = ssz;
        addr = a; store_data = 32'h1234_5678;
        #1;
        check("fault_flag",  {31'd0, lsu_fault}, 32'd1);
        check("fault_stall", {31'd0, lsu_stall}, 32'd0);
        step();
        check("fault_no_req", {31'd0, dmem_req}, 32'd0);
        step();
        check("fault_no_req2", {31'd0, dmem_req}, 32'd0);
        idle_inputs();
        #1;
        check("fault_clear", {31'd0, lsu_fault}, 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'hDEAD_BEEF;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_req",        {31'd0, dmem_req},   32'd0);
        check("rst_we",         {31'd0, dmem_we},    32'd0);
        check("rst_addr",       dmem_addr,           32'd0);
        check("rst_be",         {28'd0, dmem_be},    32'd0);
        check("rst_wdata",      dmem_wdata,          32'd0);
        check("rst_load_data",  load_data,           32'd0);
        check("rst_load_valid", {31'd0, load_valid}, 32'd0);
        check("rst_stall",      {31'd0, lsu_stall},  32'd0);
        check("rst_fault",      {31'd0, lsu_fault},  32'd0);

        // SB, then the load family on the shared read-data patterns
        do_op(1'b1, 1'b0, 3'b000, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 32'h0, 0,
              4'b1000, 32'h0000_1000, 32'hDDDD_DDDD, 32'h0);
        do_op(1'b0, 1'b1, 3'b000, 3'b000, 32'h0000_2002, 32'h0, 32'h12FE_3456, 0,
              4'b1111, 32'h0000_2000, 32'h0, 32'hFFFF_FFFE);
        do_op(1'b0, 1'b1, 3'b100, 3'b000, 32'h0000_2002, 32'h0, 32'h12FE_3456, 0,
              4'b1111, 32'h0000_2000, 32'h0, 32'h0000_00FE);
        do_op(1'b0, 1'b1, 3'b001, 3'b000, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 1,
              4'b1111, 32'h0000_2000, 32'h0, 32'hFFFF_8001);
        do_op(1'b0, 1'b1, 3'b101, 3'b000, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0,
              4'b1111, 32'h0000_2000, 32'h0, 32'h0000_8001);
        do_op(1'b0, 1'b1, 3'b010, 3'b000, 32'h0000_2000, 32'h0, 32'h8001_7FFF, 0,
              4'b1111, 32'h0000_2000, 32'h0, 32'h8001_7FFF);
        do_op(1'b0, 1'b1, 3'b000, 3'b000, 32'h0000_2001, 32'h0, 32'h12FE_3456, 0,
              4'b1111, 32'h0000_2000, 32'h0, 32'h0000_0034);
        do_op(1'b1, 1'b0, 3'b000, 3'b001, 32'h0000_0002, 32'h1122_3344, 32'h0, 0,
              4'b1100, 32'h0000_0000, 32'h3344_3344, 32'h0);

        // Faults: misaligned word/half, illegal load and store sizes
        fault_op(1'b0, 1'b1, 3'b010, 3'b000, 32'h0000_2001);
        fault_op(1'b0, 1'b1, 3'b011, 3'b000, 32'h0000_2000);
        fault_op(1'b1, 1'b0, 3'b000, 3'b100, 32'h0000_2000);
        fault_op(1'b1, 1'b0, 3'b000, 3'b001, 32'h0000_1001);

        // Ack withheld five cycles, outputs held throughout
        do_op(1'b0, 1'b1, 3'b010, 3'b000, 32'h0000_3004, 32'h0, 32'hCAFE_F00D, 5,
              4'b1111, 32'h0000_3004, 32'h0, 32'hCAFE_F00D);

        // Both flags set: treated as SW
        do_op(1'b1, 1'b1, 3'b010, 3'b010, 32'h0000_0040, 32'h0BAD_CAFE, 32'h5555_5555, 0,
              4'b1111, 32'h0000_0040, 32'h0BAD_CAFE, 32'h0);

        // Reset in third BUSY cycle abandons the access; late ack ignored
        ctrl_mem2reg = 1'b1; ctrl_load_size = 3'b010; addr = 32'h0000_5000;
        step();
        check("abort_busy1_req", {31'd0, dmem_req}, 32'd1);
        step();
        check("abort_busy2_req", {31'd0, dmem_req}, 32'd1);
        step();
        check("abort_busy3_stall", {31'd0, lsu_stall}, 32'd1);
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
        check("abort_req",   {31'd0, dmem_req},  32'd0);
        check("abort_stall", {31'd0, lsu_stall}, 32'd0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h7777_7777;
        step();
        dmem_ack = 1'b0;
        check("late_ack_valid", {31'd0, load_valid}, 32'd0);
        check("late_ack_req",   {31'd0, dmem_req},   32'd0);
        step();
        check("late_ack_valid2", {31'd0, load_valid}, 32'd0);
        check("late_ack_data",   load_data,           32'd0);

        // Stray ack in IDLE with no op
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("idle_ack_req",   {31'd0, dmem_req},   32'd0);
        check("idle_ack_valid", {31'd0, load_valid}, 32'd0);
        check("idle_ack_stall", {31'd0, lsu_stall},  32'd0);

        check("sb_req_drained",  exp_req_q.size(),  32'd0);
        check("sb_load_drained", exp_load_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
